// File: rtl/oldestn_arbiter_lss_pipe_if.sv
// Purpose: bundles the request, bypass-lane, retire and grant-stage signals of
//          the oldest-first issue arbiter.
// Ports (signals):
//   flush_i, retire_cnt_i, req_i, req_ls_i, new_req_i, new_req_ls_i, out_ready_i
//       driven by the issue window / bypass source / consumer (master side)
//   new_grant_o, head_o, gnt_valid_o, gnt_is_new_o, gnt_index_o
//       driven by the arbiter (slave side)
interface oldestn_arbiter_lss_pipe_if #(
    parameter int SEL_WIDTH      = 8,
    parameter int PRIORITY_WIDTH = 3,
    parameter int GRANT_NUM      = 2,
    parameter int NEW_NUM        = 2
);
    logic                                flush_i;
    logic [PRIORITY_WIDTH:0]             retire_cnt_i;
    logic [SEL_WIDTH-1:0]                req_i;
    logic [SEL_WIDTH-1:0]                req_ls_i;
    logic [NEW_NUM-1:0]                  new_req_i;
    logic [NEW_NUM-1:0]                  new_req_ls_i;
    logic                                out_ready_i;
    logic [NEW_NUM-1:0]                  new_grant_o;
    logic [PRIORITY_WIDTH-1:0]           head_o;
    logic [GRANT_NUM-1:0]                gnt_valid_o;
    logic [GRANT_NUM-1:0]                gnt_is_new_o;
    logic [GRANT_NUM*PRIORITY_WIDTH-1:0] gnt_index_o;

    modport master (
        output flush_i, retire_cnt_i, req_i, req_ls_i, new_req_i, new_req_ls_i, out_ready_i,
        input  new_grant_o, head_o, gnt_valid_o, gnt_is_new_o, gnt_index_o
    );

    modport slave (
        input  flush_i, retire_cnt_i, req_i, req_ls_i, new_req_i, new_req_ls_i, out_ready_i,
        output new_grant_o, head_o, gnt_valid_o, gnt_is_new_o, gnt_index_o
    );
endinterface

// File: rtl/oldestn_arbiter_lss_pipe.sv
// Purpose: N-way oldest-first issue arbiter. Age order runs from head_q around
//          the circular window, then through the bypass lanes (lane 0 first).
//          Only the single oldest load/store may issue. Up to GRANT_NUM picks
//          are registered into a valid/ready output stage.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-high
//   bus  - slave modport of oldestn_arbiter_lss_pipe_if (requests, retire,
//          flush, bypass grants, head pointer, registered grant slots)
module oldestn_arbiter_lss_pipe #(
    parameter int SEL_WIDTH      = 8,
    parameter int PRIORITY_WIDTH = 3,
    parameter int GRANT_NUM      = 2,
    parameter int NEW_NUM        = 2
) (
    input  logic clk,
    input  logic rst,
    oldestn_arbiter_lss_pipe_if.slave bus
);
    localparam int PW  = PRIORITY_WIDTH;
    localparam int TOT = SEL_WIDTH + NEW_NUM;
    localparam int CW  = PW + 2;
    localparam logic [PW:0] SEL_CNT = (PW+1)'(SEL_WIDTH);

    logic [PW-1:0]        head_q;
    logic [GRANT_NUM-1:0] valid_q;
    logic [GRANT_NUM-1:0] is_new_q;
    logic [PW-1:0]        index_q [GRANT_NUM];

    logic [SEL_WIDTH-1:0] held;
    logic [SEL_WIDTH-1:0] req_eff;
    logic [TOT-1:0]       req_age;
    logic [TOT-1:0]       ls_age;
    logic [TOT-1:0]       ls_first;
    logic [TOT-1:0]       elig;

    logic [GRANT_NUM-1:0] sel_valid;
    logic [GRANT_NUM-1:0] sel_is_new;
    logic [PW-1:0]        sel_index [GRANT_NUM];
    logic [NEW_NUM-1:0]   lane_sel;
    logic                 load;

    // Entries already sitting in a valid slot must not be granted twice.
    always_comb begin
        held = '0;
        for (int g = 0; g < GRANT_NUM; g++) begin
            if (valid_q[g] && !is_new_q[g]) held[index_q[g]] = 1'b1;
        end
    end

    assign req_eff = bus.req_i & ~held;

    // Rotate the window so bit 0 is the entry at head_q; bypass lanes follow.
    always_comb begin
        logic [PW-1:0] widx;
        widx    = '0;
        req_age = '0;
        ls_age  = '0;
        for (int p = 0; p < SEL_WIDTH; p++) begin
            widx       = head_q + PW'(p);
            req_age[p] = req_eff[widx];
            ls_age[p]  = bus.req_ls_i[widx];
        end
        req_age[SEL_WIDTH +: NEW_NUM] = bus.new_req_i;
        ls_age[SEL_WIDTH +: NEW_NUM]  = bus.new_req_ls_i;
    end

    // Lowest set bit of the age-ordered LS vector is the oldest memory op;
    // every younger LS is masked whether or not it is ready.
    assign ls_first = ls_age & (~ls_age + TOT'(1));
    assign elig     = req_age & (~ls_age | ls_first);

    // cnt is the number of eligible requests older than position p, i.e. the
    // slot that position p would occupy.
    always_comb begin
        logic [CW-1:0] cnt;
        cnt        = '0;
        sel_valid  = '0;
        sel_is_new = '0;
        lane_sel   = '0;
        for (int g = 0; g < GRANT_NUM; g++) sel_index[g] = '0;
        for (int p = 0; p < TOT; p++) begin
            for (int g = 0; g < GRANT_NUM; g++) begin
                if (elig[p] && (cnt == CW'(g))) begin
                    sel_valid[g] = 1'b1;
                    if (p < SEL_WIDTH) begin
                        sel_index[g] = head_q + PW'(p);
                    end else begin
                        sel_is_new[g]           = 1'b1;
                        sel_index[g]            = PW'(p - SEL_WIDTH);
                        lane_sel[p - SEL_WIDTH] = 1'b1;
                    end
                end
            end
            cnt = cnt + CW'(elig[p]);
        end
    end

    assign load            = ~(|valid_q) | bus.out_ready_i;
    assign bus.new_grant_o = lane_sel & {NEW_NUM{load & ~bus.flush_i & ~rst}};

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            valid_q  <= '0;
            is_new_q <= '0;
            for (int g = 0; g < GRANT_NUM; g++) index_q[g] <= '0;
        end else if (bus.flush_i) begin
            head_q   <= '0;
            valid_q  <= '0;
            is_new_q <= '0;
            for (int g = 0; g < GRANT_NUM; g++) index_q[g] <= '0;
        end else begin
            // Window size is a power of two, so dropping the top bit wraps;
            // a full-window retire leaves head unchanged.
            head_q <= head_q + bus.retire_cnt_i[PW-1:0];
            if (load) begin
                valid_q  <= sel_valid;
                is_new_q <= sel_is_new;
                for (int g = 0; g < GRANT_NUM; g++) index_q[g] <= sel_index[g];
            end
        end
    end

    assign bus.head_o       = head_q;
    assign bus.gnt_valid_o  = valid_q;
    assign bus.gnt_is_new_o = is_new_q;

    always_comb begin
        bus.gnt_index_o = '0;
        for (int g = 0; g < GRANT_NUM; g++) bus.gnt_index_o[g*PW +: PW] = index_q[g];
    end

    retire_range_a: assert property (@(posedge clk) disable iff (rst)
        bus.retire_cnt_i <= SEL_CNT);

endmodule
